// File: rtl/mas16_pkg.sv
// mas16_pkg: shared definitions for the MAS16 sequencer.
//   - opcode encodings (instruction bits [15:12])
//   - instruction field positions
//   - FSM state and opB-source enums
package mas16_pkg;

   // Arithmetic
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_SRA  = 4'h3;
   // Logic
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   // Memory
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_SET  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hB;
   // Conditional
   localparam logic [3:0] OP_SLT  = 4'hC;
   localparam logic [3:0] OP_SLTI = 4'hD;
   localparam logic [3:0] OP_BEQZ = 4'hE;
   localparam logic [3:0] OP_JMP  = 4'hF;

   // Instruction fields
   localparam int unsigned IR_OP_MSB = 15;
   localparam int unsigned IR_OP_LSB = 12;
   localparam int unsigned IR_RD_MSB = 11;
   localparam int unsigned IR_RD_LSB = 8;
   localparam int unsigned IR_RA_MSB = 7;
   localparam int unsigned IR_RA_LSB = 4;
   localparam int unsigned IR_RB_MSB = 3;
   localparam int unsigned IR_RB_LSB = 0;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      SRC_RB = 2'd0,  // register RB data
      SRC_C4 = 2'd1,  // zero-extended ir[3:0]
      SRC_C8 = 2'd2   // zero-extended ir[7:0]
   } opb_src_e;

endpackage

// File: rtl/mas16_decode.sv
// mas16_decode: combinational opcode decoder.
//   opcode_i   - instruction bits [15:12]
//   opb_src_o  - operand-B source select
//   wb_en_o    - result is written back to RD from the ALU
//   is_ld_o / is_st_o / is_br_o / is_jmp_o / is_halt_o - instruction class flags
module mas16_decode
   import mas16_pkg::*;
(
   input  logic [3:0] opcode_i,
   output opb_src_e   opb_src_o,
   output logic       wb_en_o,
   output logic       is_ld_o,
   output logic       is_st_o,
   output logic       is_br_o,
   output logic       is_jmp_o,
   output logic       is_halt_o
);

   always_comb begin
      opb_src_o = SRC_RB;
      wb_en_o   = 1'b0;
      is_ld_o   = 1'b0;
      is_st_o   = 1'b0;
      is_br_o   = 1'b0;
      is_jmp_o  = 1'b0;
      is_halt_o = 1'b0;
      unique case (opcode_i)
         OP_ADD, OP_MUL, OP_SRA, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SLT: begin
            wb_en_o = 1'b1;
         end
         OP_ADDI, OP_SLTI: begin
            opb_src_o = SRC_C4;
            wb_en_o   = 1'b1;
         end
         OP_SET: begin
            opb_src_o = SRC_C8;
            wb_en_o   = 1'b1;
         end
         OP_LD: begin
            opb_src_o = SRC_C4;
            is_ld_o   = 1'b1;
         end
         OP_ST: begin
            opb_src_o = SRC_C4;
            is_st_o   = 1'b1;
         end
         OP_BEQZ: begin
            opb_src_o = SRC_C4;
            is_br_o   = 1'b1;
         end
         OP_JMP: begin
            opb_src_o = SRC_C4;
            is_jmp_o  = 1'b1;
         end
         OP_HALT: begin
            is_halt_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mas16_ctrl.sv
// mas16_ctrl: multi-cycle fetch/decode/execute sequencer for the MAS16 datapath.
//   clk, rst_n             - clock, asynchronous active-low reset
//   mem_*                  - req/ack memory port (fetch, LD, ST)
//   rf_raddr_* / rf_rdata_* - register file read ports (RA, RB, RD fields)
//   rf_we/rf_waddr/rf_wdata - register file write port
//   alu_*                  - external combinational ALU operands, selects, result, zero flag
//   halted                 - HALT executed; only reset leaves this state
module mas16_ctrl
   import mas16_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [3:0]  rf_raddr_a,
   output logic [3:0]  rf_raddr_b,
   output logic [3:0]  rf_raddr_d,
   input  logic [15:0] rf_rdata_a,
   input  logic [15:0] rf_rdata_b,
   input  logic [15:0] rf_rdata_d,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic [15:0] alu_opA,
   output logic [15:0] alu_opB,
   output logic [15:0] alu_opD,
   output logic [1:0]  alu_selType,
   output logic [1:0]  alu_selOp,
   input  logic [15:0] alu_res,
   input  logic        alu_cbz,
   output logic        halted
);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] opa_q, opa_d;
   logic [15:0] opb_q, opb_d;
   logic [15:0] opd_q, opd_d;
   logic [15:0] res_q, res_d;

   opb_src_e    opb_src;
   logic        wb_en, is_ld, is_st, is_br, is_jmp, is_halt;
   logic [15:0] opb_sel;
   logic        req_c, we_c;
   logic [15:0] addr_c;

   mas16_decode u_decode (
      .opcode_i  (ir_q[IR_OP_MSB:IR_OP_LSB]),
      .opb_src_o (opb_src),
      .wb_en_o   (wb_en),
      .is_ld_o   (is_ld),
      .is_st_o   (is_st),
      .is_br_o   (is_br),
      .is_jmp_o  (is_jmp),
      .is_halt_o (is_halt)
   );

   always_comb begin
      unique case (opb_src)
         SRC_C4:  opb_sel = {12'h000, ir_q[IR_RB_MSB:IR_RB_LSB]};
         SRC_C8:  opb_sel = {8'h00, ir_q[IR_RA_MSB:IR_RB_LSB]};
         default: opb_sel = rf_rdata_b;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      opd_d   = opd_q;
      res_d   = res_q;
      req_c   = 1'b0;
      we_c    = 1'b0;
      addr_c  = 16'h0000;
      unique case (state_q)
         S_FETCH: begin
            req_c  = 1'b1;
            addr_c = pc_q;
            if (mem_ack) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + 16'd1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            opa_d   = rf_rdata_a;
            opb_d   = opb_sel;
            opd_d   = rf_rdata_d;
            state_d = is_halt ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            res_d = alu_res;
            if (is_jmp || (is_br && alu_cbz)) pc_d = alu_res;
            if (is_ld || is_st)               state_d = S_MEM;
            else if (wb_en)                   state_d = S_WB;
            else                              state_d = S_FETCH;
         end
         S_MEM: begin
            req_c  = 1'b1;
            we_c   = is_st;
            addr_c = res_q;
            if (mem_ack) begin
               if (is_ld) begin
                  // res_q has served as the address; reuse it to carry load data to WB
                  res_d   = mem_rdata;
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         opd_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         opd_q   <= opd_d;
         res_q   <= res_d;
      end
   end

   // Gating with rst_n drops an in-flight request the moment reset asserts and keeps
   // the port quiet while the state register sits in S_FETCH during reset.
   assign mem_req   = req_c & rst_n;
   assign mem_we    = we_c & rst_n;
   assign mem_addr  = mem_req ? addr_c : 16'h0000;
   assign mem_wdata = mem_we ? opd_q : 16'h0000;

   assign rf_raddr_a = ir_q[IR_RA_MSB:IR_RA_LSB];
   assign rf_raddr_b = ir_q[IR_RB_MSB:IR_RB_LSB];
   assign rf_raddr_d = ir_q[IR_RD_MSB:IR_RD_LSB];
   assign rf_we      = (state_q == S_WB);
   assign rf_waddr   = rf_we ? ir_q[IR_RD_MSB:IR_RD_LSB] : 4'h0;
   assign rf_wdata   = rf_we ? res_q : 16'h0000;

   assign alu_opA     = opa_q;
   assign alu_opB     = opb_q;
   assign alu_opD     = opd_q;
   assign alu_selType = ir_q[15:14];
   assign alu_selOp   = ir_q[13:12];

   assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_mas16_ctrl.sv
// tb_mas16_ctrl: self-checking bench for mas16_ctrl.
// Provides a behavioural memory with per-direction wait states, a register file and an
// ALU model. Expected memory handshakes and register writes (kind, address, data, cycle)
// are queued per program and popped as the DUT produces them.
module tb_mas16_ctrl;

   logic        clk;
   logic        rst_n;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  rf_raddr_a, rf_raddr_b, rf_raddr_d, rf_waddr;
   logic [15:0] rf_rdata_a, rf_rdata_b, rf_rdata_d, rf_wdata;
   logic        rf_we;
   logic [15:0] alu_opA, alu_opB, alu_opD, alu_res;
   logic [1:0]  alu_selType, alu_selOp;
   logic        alu_cbz;
   logic        halted;

   mas16_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .rf_raddr_a  (rf_raddr_a),
      .rf_raddr_b  (rf_raddr_b),
      .rf_raddr_d  (rf_raddr_d),
      .rf_rdata_a  (rf_rdata_a),
      .rf_rdata_b  (rf_rdata_b),
      .rf_rdata_d  (rf_rdata_d),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .alu_opA     (alu_opA),
      .alu_opB     (alu_opB),
      .alu_opD     (alu_opD),
      .alu_selType (alu_selType),
      .alu_selOp   (alu_selOp),
      .alu_res     (alu_res),
      .alu_cbz     (alu_cbz),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model
   logic [15:0] rf [16];
   assign rf_rdata_a = rf[rf_raddr_a];
   assign rf_rdata_b = rf[rf_raddr_b];
   assign rf_rdata_d = rf[rf_raddr_d];

   // ALU model
   always_comb begin
      alu_res = 16'h0000;
      case ({alu_selType, alu_selOp})
         4'h2:    alu_res = alu_opA * alu_opB;
         4'h3:    alu_res = 16'($signed(alu_opA) >>> alu_opB[3:0]);
         4'h4:    alu_res = alu_opA & alu_opB;
         4'h5:    alu_res = alu_opA | alu_opB;
         4'h6:    alu_res = ~alu_opA;
         4'h7:    alu_res = alu_opA ^ alu_opB;
         4'hA:    alu_res = alu_opB;
         4'hB:    alu_res = 16'h0000;
         4'hC,
         4'hD:    alu_res = {15'h0000, $signed(alu_opA) < $signed(alu_opB)};
         default: alu_res = alu_opA + alu_opB;  // ADD, ADDI, LD, ST, BEQZ, JMP
      endcase
   end
   assign alu_cbz = (alu_opD == 16'h0000);

   // Memory model and scoreboard
   logic [15:0] mem [logic [15:0]];
   int          rd_wait, st_wait, wait_cnt, cyc;
   int          n_checks, n_errors;

   localparam logic [3:0] EV_RD = 4'h1, EV_WR = 4'h2, EV_RF = 4'h3;

   typedef struct {
      logic [3:0]  kind;
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
   } ev_t;
   ev_t exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input logic [3:0] kind, input logic [15:0] addr,
                          input logic [15:0] data, input int c);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic got_ev(input logic [3:0] kind, input logic [15:0] addr, input logic [15:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("evt_unexpected", {kind, addr, data}, 64'h0);
      end else begin
         e = exp_q.pop_front();
         check("evt", {kind, addr, data}, {e.kind, e.addr, e.data});
         check("evt_cycle", 64'(cyc), 64'(e.cyc));
      end
   endtask

   // One clock cycle: sample at the falling edge, record events, drive ack for the next rise.
   task automatic step();
      int w;
      @(negedge clk);
      cyc++;
      if (rf_we) begin
         got_ev(EV_RF, {12'h000, rf_waddr}, rf_wdata);
         rf[rf_waddr] = rf_wdata;
      end
      if (mem_req && mem_we && exp_q.size() != 0) begin
         check("st_hold_addr", mem_addr, exp_q[0].addr);
         check("st_hold_wdata", mem_wdata, exp_q[0].data);
      end
      w = mem_we ? st_wait : rd_wait;
      if (!mem_req) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else if (wait_cnt >= w) begin
         mem_ack   = 1'b1;
         mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
         got_ev(mem_we ? EV_WR : EV_RD, mem_addr, mem_we ? mem_wdata : 16'h0000);
         wait_cnt  = 0;
      end else begin
         mem_ack  = 1'b0;
         wait_cnt++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem"}, {mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_waddr, halted}, 64'h0);
      check({tag, "_rf"}, {rf_wdata, rf_raddr_a, rf_raddr_b, rf_raddr_d}, 64'h0);
      check({tag, "_alu"}, {alu_opA, alu_opB, alu_opD, alu_selType, alu_selOp}, 64'h0);
   endtask

   // Hold reset a few cycles, check outputs, release just after a rising edge.
   task automatic reset_dut();
      rst_n     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      wait_cnt  = 0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic clear_env();
      mem.delete();
      exp_q.delete();
      for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
      rd_wait = 0;
      st_wait = 0;
   endtask

   task automatic run_to_halt(input int exp_cyc);
      int   guard;
      logic req_seen;
      guard = 0;
      while (!halted && guard < 200) begin
         step();
         guard++;
      end
      check("halt_reached", halted, 1'b1);
      check("halt_cycle", 64'(cyc), 64'(exp_cyc));
      req_seen = 1'b0;
      repeat (5) begin
         step();
         if (mem_req) req_seen = 1'b1;
      end
      check("halt_idle_req", req_seen, 1'b0);
      check("sb_drain", 64'(exp_q.size()), 64'h0);
   endtask

   initial begin
      int guard;
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      mem_ack  = 1'b0;
      mem_rdata = 16'h0000;

      // ADD R3,R1,R2 then HALT, zero-wait memory
      clear_env();
      rf[1] = 16'd5;
      rf[2] = 16'd3;
      mem[16'h0000] = 16'h0312;
      mem[16'h0001] = 16'hB000;
      push_ev(EV_RD, 16'h0000, 16'h0000, 1);
      push_ev(EV_RF, 16'h0003, 16'h0008, 4);
      push_ev(EV_RD, 16'h0001, 16'h0000, 5);
      reset_dut();
      run_to_halt(7);

      // SET, ST with 3 wait states, LD, HALT
      clear_env();
      rf[0]   = 16'h0010;
      st_wait = 3;
      mem[16'h0000] = 16'hA4AB;
      mem[16'h0001] = 16'h9402;
      mem[16'h0002] = 16'h8501;
      mem[16'h0003] = 16'hB000;
      mem[16'h0011] = 16'hBEEF;
      push_ev(EV_RD, 16'h0000, 16'h0000, 1);
      push_ev(EV_RF, 16'h0004, 16'h00AB, 4);
      push_ev(EV_RD, 16'h0001, 16'h0000, 5);
      push_ev(EV_WR, 16'h0012, 16'h00AB, 11);
      push_ev(EV_RD, 16'h0002, 16'h0000, 12);
      push_ev(EV_RD, 16'h0011, 16'h0000, 15);
      push_ev(EV_RF, 16'h0005, 16'hBEEF, 16);
      push_ev(EV_RD, 16'h0003, 16'h0000, 17);
      reset_dut();
      run_to_halt(19);

      // BEQZ taken (RD=0) then not taken (RD=5)
      clear_env();
      rf[1] = 16'd5;
      rf[6] = 16'h0020;
      rf[7] = 16'h0000;
      mem[16'h0000] = 16'hE764;
      mem[16'h0024] = 16'hE164;
      mem[16'h0025] = 16'hB000;
      push_ev(EV_RD, 16'h0000, 16'h0000, 1);
      push_ev(EV_RD, 16'h0024, 16'h0000, 4);
      push_ev(EV_RD, 16'h0025, 16'h0000, 7);
      reset_dut();
      run_to_halt(9);

      // JMP to 0xFFFF, ADD there, PC wraps to 0x0000, JMP to 8, HALT
      clear_env();
      rf[1] = 16'd5;
      rf[2] = 16'd3;
      rf[8] = 16'hFFFF;
      mem[16'h0000] = 16'hF080;
      mem[16'hFFFF] = 16'h0812;
      mem[16'h0008] = 16'hB000;
      push_ev(EV_RD, 16'h0000, 16'h0000, 1);
      push_ev(EV_RD, 16'hFFFF, 16'h0000, 4);
      push_ev(EV_RF, 16'h0008, 16'h0008, 7);
      push_ev(EV_RD, 16'h0000, 16'h0000, 8);
      push_ev(EV_RD, 16'h0008, 16'h0000, 11);
      reset_dut();
      run_to_halt(13);

      // Reset asserted while an ST waits in MEM
      clear_env();
      rf[0]   = 16'h0010;
      rf[4]   = 16'h1234;
      st_wait = 10;
      mem[16'h0000] = 16'h9402;
      push_ev(EV_RD, 16'h0000, 16'h0000, 1);
      reset_dut();
      guard = 0;
      while (!(mem_req && mem_we) && guard < 20) begin
         step();
         guard++;
      end
      check("st_in_mem", {mem_req, mem_we}, 2'b11);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_drop", {mem_req, mem_we, mem_addr, mem_wdata}, 64'h0);
      check("sb_abandon", 64'(exp_q.size()), 64'h0);
      mem[16'h0000] = 16'hB000;
      push_ev(EV_RD, 16'h0000, 16'h0000, 1);
      reset_dut();
      run_to_halt(3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
